button_pulse_gen: RTL and testbench
===================================

// Module: button_pulse_gen
// PURPOSE
//  Turns a raw, bouncing push-button level into clean single-cycle increment pulses for the downstream event counter.
//  - Synchronises btn_in and debounces both edges.
//  - Emits one pulse per debounced press, plus optional auto-repeat pulses while the button is held.
//  - Sits between the board pin and the counter's pulse input; all outputs are registered.
// PARAMETERS
//  CNT_W          16  width of internal debounce/repeat counters
//  DEBOUNCE_CYCLES 4  consecutive stable cycles required to accept a level change (>=1, < 2**CNT_W)
//  REPEAT_DELAY    8  cycles of stable hold before the first auto-repeat pulse (>=2, < 2**CNT_W)
//  REPEAT_PERIOD   4  cycles between subsequent auto-repeat pulses (>=2, < 2**CNT_W)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-low reset
//  btn_in     in   1  raw asynchronous button level, 1 = pressed
//  repeat_en  in   1  1 = auto-repeat enabled while held
//  pulse      out  1  one-cycle-high increment strobe to counter
//  btn_level  out  1  debounced button level
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE, both sync flops=0, counters=0, pulse=0, btn_level=0.
//    Reset wins over every other condition.
//  Sync: 2-flop synchroniser; btn_s = second stage. E0 = first edge sampling btn_in=1; btn_s=1 after E0+1.
//  FSM (transitions evaluated on each clk edge; cnt, rpt are CNT_W-bit):
//    IDLE     btn_level=0. btn_s=1 -> ARMING, cnt<=0.
//    ARMING   btn_s=0 -> IDLE (glitch rejected, no pulse).
//             Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, rpt<=0, pulse<=1, btn_level<=1.
//             Else cnt++.
//    HELD     btn_s=0 -> RELEASING, cnt<=0.
//             Else if repeat_en=0: rpt<=0.
//             Else if rpt==REPEAT_DELAY-1 -> REPEAT, rpt<=0, pulse<=1.
//             Else rpt++.
//    REPEAT   btn_s=0 -> RELEASING, cnt<=0.
//             Else if repeat_en=0 -> HELD, rpt<=0.
//             Else if rpt==REPEAT_PERIOD-1: pulse<=1, rpt<=0.
//             Else rpt++.
//    RELEASING  btn_level stays 1.
//             btn_s=1 -> HELD, rpt<=0 (bounce; repeat delay restarts, no pulse).
//             Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0.
//             Else cnt++.
//  pulse defaults to 0 every cycle it is not explicitly set, so it is never high for 2 consecutive cycles.
//  Latency:
//    - press pulse and btn_level rise after edge E0+DEBOUNCE_CYCLES+2.
//    - first repeat pulse after edge E0+DEBOUNCE_CYCLES+2+REPEAT_DELAY.
//    - further repeat pulses every REPEAT_PERIOD cycles.
//  Release never produces a pulse. btn_level falls DEBOUNCE_CYCLES+2 edges after the first edge sampling btn_in=0.
//  Counters never wrap: they are always cleared at their terminal value or on a state change.
//  Unreachable state encodings -> IDLE on the next edge.
// TESTING
//  1 Reset: hold rst=0 4 cycles with btn_in=1 -> pulse=0, btn_level=0 throughout; release rst -> press pulse after E0+6 (defaults).
//  2 Clean press: btn_in 0->1 held 10 cycles, repeat_en=0 -> exactly 1 pulse after E0+6, btn_level=1;
//    release -> btn_level=0 after 6 edges, no pulse.
//  3 Bounce: btn_in high 3 cycles, low 1, high 3, low -> 0 pulses, btn_level stays 0.
//    Release-side bounce of 2 cycles -> btn_level stays 1, no extra pulse.
//  4 Auto-repeat: repeat_en=1, hold 30 cycles -> pulses after E0+6, +14, +18, +22, +26, +30 (6 total), none consecutive.
//  5 repeat_en toggled to 0 in REPEAT for 5 cycles then back to 1 -> no pulses while 0; next pulse 8 cycles after re-enable.
//  6 Mid-operation reset: assert rst=0 in REPEAT -> next cycle pulse=0, btn_level=0, state IDLE;
//    release with btn_in still 1 -> fresh press pulse after 6 edges.

Source files
------------

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced push-button to single-cycle increment pulse generator
//
// Purpose:
//   Turns a raw, bouncing push-button level into clean single-cycle increment
//   pulses for a downstream event counter. The raw level is brought into the
//   clock domain by a two-flop synchroniser, both edges are debounced, one
//   pulse is issued per accepted press and, optionally, auto-repeat pulses
//   are issued while the button stays held. All outputs are registered.
//
// Parameters:
//   CNT_W            width of the debounce (cnt) and repeat (rpt) counters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change (>=1)
//   REPEAT_DELAY     held cycles before the first auto-repeat pulse (>=2)
//   REPEAT_PERIOD    cycles between later auto-repeat pulses (>=2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   btn_in     in   raw asynchronous button level, 1 = pressed
//   repeat_en  in   1 = auto-repeat while held
//   pulse      out  one-cycle-high increment strobe
//   btn_level  out  debounced button level

module button_pulse_gen #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse,
    output logic btn_level
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMING    = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        RELEASING = 3'd4
    } state_t;

    // Terminal counts. Counters are cleared when they hit these values or on
    // any state change, so they never wrap.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             sync1;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rpt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            btn_s     <= 1'b0;
            cnt       <= CNT_ZERO;
            rpt       <= CNT_ZERO;
            pulse     <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;

            // Strobe is only raised by the branches below, so it can never
            // stay high for two cycles in a row.
            pulse <= 1'b0;

            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (btn_s) begin
                        state <= ARMING;
                        cnt   <= CNT_ZERO;
                    end
                end

                ARMING: begin
                    if (!btn_s) begin
                        // Too short to be a press: drop it silently.
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        rpt       <= CNT_ZERO;
                        pulse     <= 1'b1;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASING;
                        cnt   <= CNT_ZERO;
                    end else if (!repeat_en) begin
                        rpt <= CNT_ZERO;
                    end else if (rpt == RD_LAST) begin
                        state <= REPEAT;
                        rpt   <= CNT_ZERO;
                        pulse <= 1'b1;
                    end else begin
                        rpt <= rpt + CNT_ONE;
                    end
                end

                REPEAT: begin
                    if (!btn_s) begin
                        state <= RELEASING;
                        cnt   <= CNT_ZERO;
                    end else if (!repeat_en) begin
                        // Disabling repeat falls back to HELD so re-enabling
                        // restarts the full initial delay.
                        state <= HELD;
                        rpt   <= CNT_ZERO;
                    end else if (rpt == RP_LAST) begin
                        pulse <= 1'b1;
                        rpt   <= CNT_ZERO;
                    end else begin
                        rpt <= rpt + CNT_ONE;
                    end
                end

                RELEASING: begin
                    if (btn_s) begin
                        // Release bounce: still pressed, no new pulse, but the
                        // repeat delay starts over.
                        state <= HELD;
                        rpt   <= CNT_ZERO;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= CNT_ZERO;
                    rpt       <= CNT_ZERO;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb/tb_button_pulse_gen.sv - self-checking bench for button_pulse_gen
//
// Purpose:
//   Drives directed and randomized button activity into button_pulse_gen and
//   compares pulse/btn_level every cycle against a run-length model of the
//   debounce and auto-repeat rules, plus literal timing expectations.
//
// Ports: none (top-level bench).

module tb_button_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk;
    logic rst;
    logic btn_in;
    logic repeat_en;
    logic pulse;
    logic btn_level;

    button_pulse_gen #(
        .CNT_W(16),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .repeat_en(repeat_en),
        .pulse(pulse),
        .btn_level(btn_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Edge numbers at which the DUT showed a pulse / level rise / level fall.
    int plog[$];
    int rlog[$];
    int flog[$];

    // Model state: sync pipe, accepted level, run lengths and held-enabled count.
    int m_s1       = 0;
    int m_s2       = 0;
    int m_level    = 0;
    int m_one_run  = 0;
    int m_zero_run = 0;
    int m_hold     = 0;
    int m_pulse    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Level flips after D+1 consecutive synchronised samples opposing it; a
    // press flip emits a pulse. While pressed, the count of consecutive
    // enabled held samples produces pulses at RD, RD+RP, RD+2RP, ...
    task automatic model_step();
        int bs;
        m_pulse = 0;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            m_one_run = 0; m_zero_run = 0; m_hold = 0;
        end else begin
            bs   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(btn_in);
            if (m_level == 0) begin
                if (bs != 0) begin
                    m_one_run++;
                    if (m_one_run == D + 1) begin
                        m_level = 1; m_pulse = 1;
                        m_one_run = 0; m_zero_run = 0; m_hold = 0;
                    end
                end else begin
                    m_one_run = 0;
                end
            end else begin
                if (bs == 0) begin
                    m_zero_run++;
                    if (m_zero_run == D + 1) begin
                        m_level = 0; m_zero_run = 0; m_one_run = 0;
                    end
                end else if (m_zero_run > 0) begin
                    m_zero_run = 0;
                    m_hold = 0;
                end else if (repeat_en) begin
                    m_hold++;
                    if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0)) m_pulse = 1;
                end else begin
                    m_hold = 0;
                end
            end
        end
    endtask

    // Per-cycle compare, sampled 1 time unit after the rising edge.
    initial begin
        int prev_pulse;
        int prev_level;
        prev_pulse = 0;
        prev_level = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            chk("pulse", int'(pulse), m_pulse);
            chk("btn_level", int'(btn_level), m_level);
            if (pulse) begin
                plog.push_back(cyc);
                chk("pulse_back_to_back", prev_pulse, 0);
            end
            if (btn_level && prev_level == 0) rlog.push_back(cyc);
            if (!btn_level && prev_level == 1) flog.push_back(cyc);
            prev_pulse = int'(pulse);
            prev_level = int'(btn_level);
        end
    end

    function automatic int count_in(input int kind, input int a, input int b);
        int n = 0;
        int sz = (kind == 0) ? plog.size() : (kind == 1) ? rlog.size() : flog.size();
        for (int i = 0; i < sz; i++) begin
            int v = (kind == 0) ? plog[i] : (kind == 1) ? rlog[i] : flog[i];
            if (v >= a && v <= b) n++;
        end
        return n;
    endfunction

    function automatic int first_from(input int kind, input int a);
        int sz = (kind == 0) ? plog.size() : (kind == 1) ? rlog.size() : flog.size();
        for (int i = 0; i < sz; i++) begin
            int v = (kind == 0) ? plog[i] : (kind == 1) ? rlog[i] : flog[i];
            if (v >= a) return v;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    localparam int KP = 0;
    localparam int KR = 1;
    localparam int KF = 2;

    int e0, f0, s0, d0, c0;
    int offs[6];

    initial begin
        offs[0] = 6; offs[1] = 14; offs[2] = 18; offs[3] = 22; offs[4] = 26; offs[5] = 30;

        // Reset held with the button pressed, then released.
        rst = 1'b0; btn_in = 1'b1; repeat_en = 1'b0;
        tick(4);
        chk("t1_no_pulse_in_reset", count_in(KP, 1, cyc), 0);
        chk("t1_no_level_in_reset", count_in(KR, 1, cyc), 0);
        rst = 1'b1;
        e0 = cyc + 1;
        tick(12);
        chk("t1_press_edge", first_from(KP, e0), e0 + 6);
        chk("t1_press_count", count_in(KP, e0, cyc), 1);
        btn_in = 1'b0;
        f0 = cyc + 1;
        tick(10);
        chk("t1_release_fall", first_from(KF, f0), f0 + 6);

        // Clean press, no repeat.
        tick(3);
        btn_in = 1'b1;
        e0 = cyc + 1;
        tick(10);
        btn_in = 1'b0;
        f0 = cyc + 1;
        tick(10);
        chk("t2_press_edge", first_from(KP, e0), e0 + 6);
        chk("t2_rise_edge", first_from(KR, e0), e0 + 6);
        chk("t2_pulse_count", count_in(KP, e0, cyc), 1);
        chk("t2_release_fall", first_from(KF, f0), f0 + 6);

        // Press-side bounce: never long enough.
        s0 = cyc + 1;
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0; tick(8);
        chk("t3_bounce_pulses", count_in(KP, s0, cyc), 0);
        chk("t3_bounce_rises", count_in(KR, s0, cyc), 0);

        // Release-side bounce of 2 cycles.
        s0 = cyc + 1;
        btn_in = 1'b1; tick(10);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(6);
        btn_in = 1'b0;
        f0 = cyc + 1;
        tick(10);
        chk("t3_rel_pulses", count_in(KP, s0, cyc), 1);
        chk("t3_rel_no_early_fall", count_in(KF, s0, f0), 0);
        chk("t3_rel_fall", first_from(KF, f0), f0 + 6);

        // Auto-repeat over a 30-cycle hold.
        repeat_en = 1'b1;
        btn_in = 1'b1;
        e0 = cyc + 1;
        tick(30);
        btn_in = 1'b0;
        tick(10);
        chk("t4_pulse_count", count_in(KP, e0, cyc), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t4_pulse_at_%0d", offs[i]), count_in(KP, e0 + offs[i], e0 + offs[i]), 1);

        // repeat_en dropped for 5 cycles while repeating.
        btn_in = 1'b1;
        e0 = cyc + 1;
        tick(16);
        repeat_en = 1'b0;
        d0 = cyc;
        tick(5);
        repeat_en = 1'b1;
        c0 = cyc;
        tick(12);
        btn_in = 1'b0;
        tick(10);
        chk("t5_first_repeat", first_from(KP, e0 + 7), e0 + 14);
        chk("t5_quiet_window", count_in(KP, d0 + 1, c0 + 7), 0);
        chk("t5_reenable_pulse", first_from(KP, d0 + 1), c0 + 8);

        // Reset in the middle of repeating, button still held afterwards.
        btn_in = 1'b1;
        e0 = cyc + 1;
        tick(16);
        rst = 1'b0;
        s0 = cyc + 1;
        tick(1);
        chk("t6_reset_drops_level", first_from(KF, s0), s0);
        chk("t6_reset_no_pulse", count_in(KP, s0, s0), 0);
        rst = 1'b1;
        e0 = cyc + 1;
        tick(10);
        chk("t6_fresh_press", first_from(KP, e0), e0 + 6);
        chk("t6_fresh_count", count_in(KP, e0, cyc), 1);
        btn_in = 1'b0;
        tick(10);

        // Randomized bouncing, holds, repeat toggles and occasional resets.
        for (int i = 0; i < 250; i++) begin
            int len;
            btn_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat_en = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 4) == 0) len = int'($urandom_range(10, 40));
            else len = int'($urandom_range(1, 7));
            tick(len);
        end
        rst = 1'b1;
        btn_in = 1'b0;
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
